// File: rtl/bcd_ex3_pkg.sv
// Shared types and constants for the BCD to Excess-3 sequencer.
package bcd_ex3_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [NIB_W-1:0] EX3_OFFSET = 4'd3;
  localparam logic [NIB_W-1:0] BCD_MAX    = 4'd9;

endpackage

// File: rtl/bcd_ex3_digit.sv
// Combinational single-digit BCD to Excess-3 converter with out-of-range flag.
module bcd_ex3_digit
  import bcd_ex3_pkg::*;
(
  input  logic [NIB_W-1:0] d,
  output logic [NIB_W-1:0] ex3,
  output logic             invalid
);

  // 4-bit wrap is intentional: no carry leaves the digit
  assign ex3     = d + EX3_OFFSET;
  assign invalid = (d > BCD_MAX);

endmodule

// File: rtl/bcd_ex3_seq_ctrl.sv
// Multi-digit BCD to Excess-3 sequencer sharing one digit converter, LSB digit first.
// Optional digit range checking is enabled with `define BCD_EX3_DIGIT_CHECK_EN.
module bcd_ex3_seq_ctrl
  import bcd_ex3_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NIB_W*DIGITS-1:0]   in_bcd,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NIB_W*DIGITS-1:0]   out_ex3,
  output logic                      out_err,
  output logic                      busy
);

  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned WORD_W = NIB_W * DIGITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

`ifdef BCD_EX3_DIGIT_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WORD_W-1:0]   cap_q, cap_d;
  logic [WORD_W-1:0]   res_q, res_d;
  logic                err_q, err_d;
  logic                in_ready_q, out_valid_q, busy_q;

  logic [NIB_W-1:0]    cur_digit;
  logic [NIB_W-1:0]    digit_ex3;
  logic                digit_invalid;
  logic [NIB_W-1:0]    nib_c;

  assign cur_digit = cap_q[int'(idx_q)*NIB_W +: NIB_W];

  bcd_ex3_digit u_digit (
    .d       (cur_digit),
    .ex3     (digit_ex3),
    .invalid (digit_invalid)
  );

  // Out-of-range digits are zeroed only when checking is built in
  assign nib_c = (CHECK_EN && digit_invalid) ? '0 : digit_ex3;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cap_d   = cap_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          cap_d   = in_bcd;
          res_d   = '0;
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        res_d[int'(idx_q)*NIB_W +: NIB_W] = nib_c;
        err_d = err_q | (CHECK_EN & digit_invalid);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake/status flags are registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cap_q       <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cap_q       <= cap_d;
      res_q       <= res_d;
      err_q       <= err_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_ex3   = res_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_bcd_ex3_seq_ctrl.sv
// Scoreboard bench for bcd_ex3_seq_ctrl (4-digit and 1-digit instances).
module tb_bcd_ex3_seq_ctrl;

  typedef struct packed {
    logic [15:0] ex3;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_err, busy;
  logic [15:0] in_bcd, out_ex3;

  logic        d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready, d1_out_err, d1_busy;
  logic [3:0]  d1_in_bcd, d1_out_ex3;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  bcd_ex3_seq_ctrl #(.DIGITS(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_bcd(in_bcd),
    .out_valid(out_valid), .out_ready(out_ready), .out_ex3(out_ex3),
    .out_err(out_err), .busy(busy)
  );

  bcd_ex3_seq_ctrl #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_bcd(d1_in_bcd),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_ex3(d1_out_ex3),
    .out_err(d1_out_err), .busy(d1_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] w);
    exp_t       e;
    logic [3:0] d;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      d = w[4*i +: 4];
`ifdef BCD_EX3_DIGIT_CHECK_EN
      if (d > 4'd9) begin
        e.err = 1'b1;
        d     = 4'h0;
      end else begin
        d = d + 4'd3;
      end
`else
      d = d + 4'd3;
`endif
      e.ex3[4*i +: 4] = d;
    end
    return e;
  endfunction

  // One full word: accept, bounded wait for result, optional output stall, handshake
  task automatic xfer(input logic [15:0] w, input logic [15:0] ex, input logic er, input int stall);
    int   n;
    exp_t e;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("accept_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_bcd   = w;
    sb.push_back('{ex3: ex, err: er});
    @(negedge clk);
    in_bcd = 16'($urandom);
    chk("busy_in_conv", 32'(busy), 32'd1);
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      chk("in_ready_low_conv", 32'(in_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'd4);
    out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_ex3", 32'(out_ex3), 32'(sb[0].ex3));
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("out_ex3", 32'(out_ex3), 32'(e.ex3));
      chk("out_err", 32'(out_err), 32'(e.err));
    end
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", 32'(out_valid), 32'd0);
    chk("ready_back", 32'(in_ready), 32'd1);
    chk("ex3_retained", 32'(out_ex3), 32'(e.ex3));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t       m;
    logic [15:0] w;
    logic [3:0]  dv, ev;
    logic        er;
    int          n;

    rst = 1'b1; in_valid = 1'b0; in_bcd = '0; out_ready = 1'b0;
    d1_in_valid = 1'b0; d1_in_bcd = '0; d1_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_ex3", 32'(out_ex3), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    xfer(16'h1234, 16'h4567, 1'b0, 0);
    xfer(16'h0999, 16'h3CCC, 1'b0, 0);
    xfer(16'h9870, 16'hCBA3, 1'b0, 0);
    xfer(16'h4321, 16'h7654, 1'b0, 5);

    // Reset during the second conversion cycle discards the word
    in_valid = 1'b1; in_bcd = 16'h5555;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_ex3", 32'(out_ex3), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    xfer(16'h0000, 16'h3333, 1'b0, 0);

`ifdef BCD_EX3_DIGIT_CHECK_EN
    xfer(16'h12A4, 16'h4507, 1'b1, 2);
`else
    xfer(16'h12A4, 16'h45D7, 1'b0, 2);
`endif
    xfer(16'h0009, 16'h333C, 1'b0, 0);

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) w[4*i +: 4] = 4'($urandom_range(0, 9));
      m = model(w);
      xfer(w, m.ex3, m.err, k);
    end

    // Single-digit instance across every nibble value
    d1_out_ready = 1'b1;
    for (int d = 0; d < 16; d++) begin
      dv = 4'(d);
`ifdef BCD_EX3_DIGIT_CHECK_EN
      ev = (dv > 4'd9) ? 4'h0 : dv + 4'd3;
      er = (dv > 4'd9);
`else
      ev = dv + 4'd3;
      er = 1'b0;
`endif
      chk("d1_in_ready", 32'(d1_in_ready), 32'd1);
      d1_in_valid = 1'b1;
      d1_in_bcd   = dv;
      @(negedge clk);
      d1_in_valid = 1'b0;
      n = 0;
      while (d1_out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      chk("d1_latency", 32'(n), 32'd1);
      chk("d1_out_ex3", 32'(d1_out_ex3), 32'(ev));
      chk("d1_out_err", 32'(d1_out_err), 32'(er));
      @(negedge clk);
    end
    d1_out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
